reg_bank_173: RTL

Parametrised successor to the team's 4-bit 74173-style load register: a bank of DEPTH registers, each WIDTH bits, with per-cycle hold/load/increment/clear operations on one selected register and a registered, output-enabled read port. It serves SAP-1 datapath storage (A, B, MAR, OUT and a PC-like counter) from one block. The read port drives zero when disabled, so several banks can be OR-combined onto the W bus.

---
 rtl/reg_bank_pkg.sv | 20 ++
 rtl/reg_bank_cell.sv | 44 ++++
 rtl/reg_bank_173.sv | 88 ++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank_173 register bank: operation encoding
// and the select-width helper used to size the wsel/rsel ports.
package reg_bank_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_INC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // A single-register bank still needs a one-bit select so out-of-range
  // indices stay representable.
  function automatic int sel_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One WIDTH-bit storage cell of the register bank: op decode, next-value
// computation, async clear, and rollover detection for INC.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_we,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_fwd,
  output logic [WIDTH-1:0] o_rd,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_val;
    case (i_op)
      OP_HOLD:  w_next = r_val;
      OP_LOAD:  w_next = i_d;
      OP_INC:   w_next = r_val + WIDTH'(1);
      OP_CLEAR: w_next = '0;
      default:  w_next = r_val;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_val <= '0;
    end else if (i_we) begin
      r_val <= w_next;
    end
  end

  // i_fwd presents the post-operation value to the read mux (write-through).
  assign o_rd   = i_fwd ? w_next : r_val;
  assign o_wrap = i_we && (i_op == OP_INC) && (&r_val);

endmodule

// File: rtl/reg_bank_173.sv
// Bank of DEPTH WIDTH-bit registers with hold/load/inc/clear on one selected
// register per cycle and a registered, output-enabled read port.
// Define REG_BANK_BYPASS_EN for write-through reads of the register being written.
module reg_bank_173
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [OP_W-1:0]  op,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    rsel,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             wrap
);

  op_e              w_op;
  logic [DEPTH-1:0] w_we;
  logic [DEPTH-1:0] w_fwd;
  logic [DEPTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_cell_rd [DEPTH];
  logic [WIDTH-1:0] w_rd_data;
  logic             w_rd_hit;

  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_wrap;

  assign w_op = op_e'(op);

  // An out-of-range wsel matches no cell, so the op degrades to HOLD.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    assign w_we[gi] = (wsel == AW'(gi));
`ifdef REG_BANK_BYPASS_EN
    assign w_fwd[gi] = w_we[gi] && (w_op != OP_HOLD);
`else
    assign w_fwd[gi] = 1'b0;
`endif

    reg_bank_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk    (clk),
      .clr_n  (clr_n),
      .i_we   (w_we[gi]),
      .i_op   (w_op),
      .i_d    (d),
      .i_fwd  (w_fwd[gi]),
      .o_rd   (w_cell_rd[gi]),
      .o_wrap (w_wrap[gi])
    );
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsel == AW'(i)) begin
        w_rd_data = w_cell_rd[i];
        w_rd_hit  = 1'b1;
      end
    end
  end

  // Output stage: zero when disabled so banks can be OR-combined on a bus.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_q       <= (oe && w_rd_hit) ? w_rd_data : '0;
      r_q_valid <= oe && w_rd_hit;
      r_wrap    <= |w_wrap;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign wrap    = r_wrap;

endmodule
